// File: rtl/multi_tone_gen_if.sv
// multi_tone_gen_if: control and output bundle for the multi-channel tone core.
// The phase_sync strobe exists only when MULTI_TONE_GEN_PHASE_SYNC_EN is defined.
interface multi_tone_gen_if #(
    parameter int NUM_CH  = 4,
    parameter int SCALE_W = 6,
    parameter int OUT_W   = 8
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int MW = OUT_W + $clog2(NUM_CH);

    logic              plus;
    logic              minus;
    logic [CW-1:0]     ch_sel;
    logic [1:0]        mode_in;
    logic              mode_we;
    logic [NUM_CH-1:0] enable;
`ifdef MULTI_TONE_GEN_PHASE_SYNC_EN
    logic              phase_sync;
`endif
    logic [SCALE_W-1:0] cur_scale;
    logic [MW-1:0]      mix;
    logic               pulse;

`ifdef MULTI_TONE_GEN_PHASE_SYNC_EN
    modport master (output plus, minus, ch_sel, mode_in, mode_we, enable, phase_sync,
                    input  cur_scale, mix, pulse);
    modport slave  (input  plus, minus, ch_sel, mode_in, mode_we, enable, phase_sync,
                    output cur_scale, mix, pulse);
`else
    modport master (output plus, minus, ch_sel, mode_in, mode_we, enable,
                    input  cur_scale, mix, pulse);
    modport slave  (input  plus, minus, ch_sel, mode_in, mode_we, enable,
                    output cur_scale, mix, pulse);
`endif
endinterface

// File: rtl/multi_tone_gen.sv
// multi_tone_gen: NUM_CH phase-accumulator tone channels, each with a saturating
// frequency scale and a selectable waveform, summed into a registered mix and a
// PWM pulse. Define MULTI_TONE_GEN_PHASE_SYNC_EN to add the phase_sync strobe
// that clears every accumulator at once.
module multi_tone_gen #(
    parameter int NUM_CH    = 4,
    parameter int SCALE_W   = 6,
    parameter int SCALE_RST = 8,
    parameter int ACC_W     = 24,
    parameter int INC_STEP  = 16,
    parameter int OUT_W     = 8
) (
    input  logic            sysclk,
    input  logic            reset,
    multi_tone_gen_if.slave bus
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int MW = OUT_W + $clog2(NUM_CH);
    localparam logic [SCALE_W-1:0] SCALE_MAX  = '1;
    localparam logic [OUT_W-1:0]   SAMPLE_MAX = '1;

    logic [SCALE_W-1:0] scale_q  [NUM_CH];
    logic [SCALE_W-1:0] scale_d  [NUM_CH];
    logic [1:0]         mode_q   [NUM_CH];
    logic [1:0]         mode_d   [NUM_CH];
    logic [ACC_W-1:0]   acc_q    [NUM_CH];
    logic [ACC_W-1:0]   acc_d    [NUM_CH];
    logic [ACC_W-1:0]   inc      [NUM_CH];
    logic [OUT_W-1:0]   sample_q [NUM_CH];
    logic [OUT_W-1:0]   sample_d [NUM_CH];
    logic [MW-1:0]      mix_q;
    logic [MW-1:0]      mix_d;
    logic [MW-1:0]      cnt_q;
    logic               pulse_q;
    logic [SCALE_W-1:0] curScale;
    logic               phaseClr;

`ifdef MULTI_TONE_GEN_PHASE_SYNC_EN
    assign phaseClr = bus.phase_sync;
`else
    assign phaseClr = 1'b0;
`endif

    // Apply plus/minus/mode writes to the addressed channel only; an out-of-range
    // ch_sel matches no channel, so its strobes fall away.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            scale_d[i] = scale_q[i];
            mode_d[i]  = mode_q[i];
            if (bus.ch_sel == CW'(i)) begin
                if (bus.plus && !bus.minus && (scale_q[i] != SCALE_MAX)) begin
                    scale_d[i] = scale_q[i] + SCALE_W'(1);
                end else if (bus.minus && !bus.plus && (scale_q[i] != '0)) begin
                    scale_d[i] = scale_q[i] - SCALE_W'(1);
                end
                if (bus.mode_we) begin
                    mode_d[i] = bus.mode_in;
                end
            end
        end
    end

    // Readback of the selected channel's scale, zero when nothing is addressed.
    always_comb begin
        curScale = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_sel == CW'(i)) begin
                curScale = scale_q[i];
            end
        end
    end

    // Phase step per channel follows the registered scale, so a new scale takes
    // effect one cycle after its strobe.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            inc[i] = (ACC_W'(scale_q[i]) + ACC_W'(1)) * ACC_W'(INC_STEP);
        end
    end

    // Next accumulator phase and waveform sample; a disabled channel keeps its
    // phase but contributes silence.
    always_comb begin
        logic [OUT_W-1:0] triBits;
        triBits = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (phaseClr) begin
                acc_d[i] = '0;
            end else if (bus.enable[i]) begin
                acc_d[i] = acc_q[i] + inc[i];
            end else begin
                acc_d[i] = acc_q[i];
            end

            triBits = acc_q[i][ACC_W-2 -: OUT_W];
            case (mode_q[i])
                2'd0:    sample_d[i] = acc_q[i][ACC_W-1] ? SAMPLE_MAX : '0;
                2'd1:    sample_d[i] = acc_q[i][ACC_W-1 -: OUT_W];
                2'd2:    sample_d[i] = acc_q[i][ACC_W-1] ? ~triBits : triBits;
                default: sample_d[i] = (acc_q[i][ACC_W-1 -: 2] == 2'b00) ? SAMPLE_MAX : '0;
            endcase
            if (!bus.enable[i]) begin
                sample_d[i] = '0;
            end
        end
    end

    // Sum of channel samples; MW is wide enough that it cannot overflow.
    always_comb begin
        mix_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mix_d = mix_d + MW'(sample_q[i]);
        end
    end

    // Channel state registers; reset restores defaults ahead of any strobe.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                scale_q[i]  <= SCALE_W'(SCALE_RST);
                mode_q[i]   <= '0;
                acc_q[i]    <= '0;
                sample_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                scale_q[i]  <= scale_d[i];
                mode_q[i]   <= mode_d[i];
                acc_q[i]    <= acc_d[i];
                sample_q[i] <= sample_d[i];
            end
        end
    end

    // Mix register and free-running PWM comparing the counter against the mix.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            mix_q   <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            mix_q   <= mix_d;
            cnt_q   <= cnt_q + MW'(1);
            pulse_q <= (cnt_q < mix_q);
        end
    end

    assign bus.cur_scale = curScale;
    assign bus.mix       = mix_q;
    assign bus.pulse     = pulse_q;

endmodule

// File: tb/tb_multi_tone_gen.sv
// tb_multi_tone_gen: directed bench for multi_tone_gen (NUM_CH=4, plus a NUM_CH=3
// instance for out-of-range channel selects). Phase-sync steps are compiled in
// when MULTI_TONE_GEN_PHASE_SYNC_EN is defined.
module tb_multi_tone_gen;
    logic sysclk;
    logic reset;
    int   assertCount;
    int   failCount;
    int   edgeCount;
    int   pulseHigh;

    multi_tone_gen_if #(.NUM_CH(4), .SCALE_W(6), .OUT_W(8)) bus ();
    multi_tone_gen_if #(.NUM_CH(3), .SCALE_W(6), .OUT_W(8)) bus3 ();

    multi_tone_gen #(.NUM_CH(4)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    multi_tone_gen #(.NUM_CH(3)) dut3 (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus3)
    );

    // Free-running 10-unit clock
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Advance one rising edge and settle just past it
    task automatic tick();
        @(posedge sysclk);
        #1;
        edgeCount++;
    endtask

    // Advance until the edge counter reaches target
    task automatic runTo(input int target);
        while (edgeCount < target) tick();
    endtask

    // Present one strobe cycle on the main instance
    task automatic applyStimulus(input logic p, input logic m, input logic [1:0] sel,
                                 input logic we, input logic [1:0] md);
        bus.plus    = p;
        bus.minus   = m;
        bus.ch_sel  = sel;
        bus.mode_we = we;
        bus.mode_in = md;
        tick();
        bus.plus    = 1'b0;
        bus.minus   = 1'b0;
        bus.mode_we = 1'b0;
    endtask

    // One counted comparison
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        edgeCount   = 0;
        bus.plus = 0; bus.minus = 0; bus.ch_sel = 0; bus.mode_in = 0; bus.mode_we = 0; bus.enable = 0;
        bus3.plus = 0; bus3.minus = 0; bus3.ch_sel = 0; bus3.mode_in = 0; bus3.mode_we = 0; bus3.enable = 0;
`ifdef MULTI_TONE_GEN_PHASE_SYNC_EN
        bus.phase_sync  = 0;
        bus3.phase_sync = 0;
`endif

        $display("[TB] step 1: defaults, reset beats a concurrent plus strobe");
        reset    = 1'b1;
        bus.plus = 1'b1;
        tick();
        tick();
        bus.plus = 1'b0;
        reset    = 1'b0;
        for (int s = 0; s < 4; s++) begin
            bus.ch_sel = s[1:0];
            #1;
            checkOutput($sformatf("rst_scale_ch%0d", s), 32'(bus.cur_scale), 32'd8);
        end
        pulseHigh = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            pulseHigh += int'(bus.pulse);
        end
        checkOutput("idle_mix", 32'(bus.mix), 32'd0);
        checkOutput("idle_pulse_highs", 32'(pulseHigh), 32'd0);

        $display("[TB] step 2: increment, simultaneous strobes, saw on channel 1");
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b0, 2'd1, 1'b0, 2'd0);
        checkOutput("plus3_scale", 32'(bus.cur_scale), 32'd11);
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 2'd0);
        checkOutput("plus_minus_scale", 32'(bus.cur_scale), 32'd11);
        applyStimulus(1'b0, 1'b0, 2'd1, 1'b1, 2'd1);
        checkOutput("mode_write_scale", 32'(bus.cur_scale), 32'd11);
        bus.enable = 4'b0010;
        edgeCount  = 0;
        runTo(4002);
        checkOutput("saw_ch1_mix", 32'(bus.mix), 32'd11);
        bus.enable = 4'b0000;
        tick();
        tick();
        checkOutput("disable_mix", 32'(bus.mix), 32'd0);
        for (int c = 0; c < 20; c++) tick();
        bus.enable = 4'b0010;
        tick();
        checkOutput("reenable_first_mix", 32'(bus.mix), 32'd0);
        tick();
        checkOutput("reenable_phase_mix", 32'(bus.mix), 32'd11);
        bus.enable = 4'b0000;

        $display("[TB] step 3: saturation and out-of-range channel select");
        for (int c = 0; c < 9; c++) applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 2'd0);
        checkOutput("minus_sat_scale", 32'(bus.cur_scale), 32'd0);
        for (int c = 0; c < 70; c++) applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 2'd0);
        checkOutput("plus_sat_scale", 32'(bus.cur_scale), 32'd63);
        bus.ch_sel = 2'd1;
        #1;
        checkOutput("ch1_untouched", 32'(bus.cur_scale), 32'd11);
        bus.ch_sel = 2'd0;
        #1;
        checkOutput("ch0_untouched", 32'(bus.cur_scale), 32'd8);
        bus3.ch_sel  = 2'd3;
        bus3.plus    = 1'b1;
        bus3.mode_we = 1'b1;
        bus3.mode_in = 2'd1;
        tick();
        tick();
        bus3.plus    = 1'b0;
        bus3.mode_we = 1'b0;
        checkOutput("n3_illegal_scale", 32'(bus3.cur_scale), 32'd0);
        for (int s = 0; s < 3; s++) begin
            bus3.ch_sel = s[1:0];
            #1;
            checkOutput($sformatf("n3_scale_ch%0d", s), 32'(bus3.cur_scale), 32'd8);
        end
        tick();

        $display("[TB] step 4: square wave on channel 0 at scale 63");
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 60; c++) applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        checkOutput("sq_scale", 32'(bus.cur_scale), 32'd63);
        bus.enable = 4'b0001;
        edgeCount  = 0;
        runTo(8193);
        checkOutput("sq_before_rise", 32'(bus.mix), 32'd0);
        tick();
        checkOutput("sq_rise", 32'(bus.mix), 32'd255);
        runTo(8199);
        pulseHigh = 0;
        for (int c = 0; c < 1024; c++) begin
            tick();
            pulseHigh += int'(bus.pulse);
        end
        checkOutput("sq_duty_highs", 32'(pulseHigh), 32'd255);
        runTo(16385);
        checkOutput("sq_before_fall", 32'(bus.mix), 32'd255);
        tick();
        checkOutput("sq_fall", 32'(bus.mix), 32'd0);

        $display("[TB] step 5: all four modes summed at scale 63");
        bus.enable = 4'b0000;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 2'd1);
        for (int c = 0; c < 59; c++) applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 2'd1, 1'b1, 2'd2);
        for (int c = 0; c < 59; c++) applyStimulus(1'b1, 1'b0, 2'd1, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b1, 2'd3);
        for (int c = 0; c < 59; c++) applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b0, 2'd3, 1'b1, 2'd0);
        for (int c = 0; c < 59; c++) applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 2'd0);
        checkOutput("sum_scale_ch3", 32'(bus.cur_scale), 32'd63);
        bus.enable = 4'b1111;
        edgeCount  = 0;
        runTo(1);
        checkOutput("sum_k1", 32'(bus.mix), 32'd0);
        runTo(2);
        checkOutput("sum_k2", 32'(bus.mix), 32'd255);
        runTo(2002);
        checkOutput("sum_k2002", 32'(bus.mix), 32'd348);
        runTo(6002);
        checkOutput("sum_k6002", 32'(bus.mix), 32'd280);
        runTo(10002);
        checkOutput("sum_k10002", 32'(bus.mix), 32'd610);
        runTo(14002);
        checkOutput("sum_k14002", 32'(bus.mix), 32'd547);

`ifdef MULTI_TONE_GEN_PHASE_SYNC_EN
        $display("[TB] step 6: phase sync realigns all channels");
        bus.enable = 4'b0000;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 60; c++) applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        bus.enable = 4'b1111;
        edgeCount  = 0;
        runTo(9000);
        checkOutput("presync_mix", 32'(bus.mix), 32'd255);
        for (int c = 0; c < 60; c++) applyStimulus(1'b1, 1'b0, 2'd1, 1'b0, 2'd0);
        for (int c = 0; c < 60; c++) applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 2'd0);
        for (int c = 0; c < 60; c++) applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 2'd0);
        bus.phase_sync = 1'b1;
        tick();
        bus.phase_sync = 1'b0;
        edgeCount = 0;
        runTo(1);
        checkOutput("sync_plus1_mix", 32'(bus.mix), 32'd255);
        runTo(2);
        checkOutput("sync_plus2_mix", 32'(bus.mix), 32'd0);
        runTo(8193);
        checkOutput("sync_before_rise", 32'(bus.mix), 32'd0);
        tick();
        checkOutput("sync_rise_all", 32'(bus.mix), 32'd1020);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
